// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: 16-way round-robin arbiter with hold limit and a registered
// 1-bit data mux that forwards the granted requester's data bit.
module rr_mux_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] data_in,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        grant_valid,
    output logic        data_out,
    output logic        data_valid
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d, sel_q, sel_d, pick;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [15:0] grant_q, grant_d;
    logic        gv_q, gv_d, dout_q, dout_d, dv_q, dv_d;

    // Descending scan so the smallest offset from ptr wins.
    always_comb begin
        pick = ptr_q;
        for (int i = 15; i >= 0; i--)
            if (req[ptr_q + 4'(i)]) pick = ptr_q + 4'(i);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        hcnt_d  = hcnt_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = BUSY;
                sel_d   = pick;
                grant_d = 16'b1 << pick;
                gv_d    = 1'b1;
                hcnt_d  = 8'd0;
            end
        end else if (!req[sel_q] || hcnt_q == HOLD_LAST) begin
            state_d = IDLE;
            grant_d = 16'b0;
            gv_d    = 1'b0;
            ptr_d   = sel_q + 4'd1;
        end else begin
            hcnt_d = hcnt_q + 8'd1;
        end
        dout_d = gv_q ? data_in[sel_q] : 1'b0;
        dv_d   = gv_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            sel_q   <= 4'd0;
            hcnt_q  <= 8'd0;
            grant_q <= 16'b0;
            gv_q    <= 1'b0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            hcnt_q  <= hcnt_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end

    assign grant       = grant_q;
    assign sel         = sel_q;
    assign grant_valid = gv_q;
    assign data_out    = dout_q;
    assign data_valid  = dv_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of rr_mux_arbiter with MAX_HOLD = 8 and 1.
module tb_rr_mux_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, rst_nb;
    logic [15:0] req, data_in, req_b, data_in_b;
    logic [15:0] grant, grant_b;
    logic [3:0]  sel, sel_b;
    logic        grant_valid, data_out, data_valid;
    logic        gv_b, dout_b, dv_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.MAX_HOLD(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .grant(grant), .sel(sel), .grant_valid(grant_valid),
        .data_out(data_out), .data_valid(data_valid)
    );

    rr_mux_arbiter #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_nb), .req(req_b), .data_in(data_in_b),
        .grant(grant_b), .sel(sel_b), .grant_valid(gv_b),
        .data_out(dout_b), .data_valid(dv_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rst_nb = 1'b0;
        req = 16'h0; data_in = 16'h0; req_b = 16'hFFFF; data_in_b = 16'h0;
        tick(); tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_gv", 32'(grant_valid), 32'h0);
        check("rst_dout", 32'(data_out), 32'h0);
        check("rst_dv", 32'(data_valid), 32'h0);
        check("rst_b_gv", 32'(gv_b), 32'h0);

        // Basic grant and data path
        rst_n = 1'b1; req = 16'h0010; data_in = 16'h0010;
        tick();
        check("basic_sel", 32'(sel), 32'h4);
        check("basic_grant", 32'(grant), 32'h0010);
        check("basic_gv", 32'(grant_valid), 32'h1);
        check("basic_dv0", 32'(data_valid), 32'h0);
        tick();
        check("basic_dout1", 32'(data_out), 32'h1);
        check("basic_dv1", 32'(data_valid), 32'h1);
        data_in = 16'hFFEF;
        tick();
        check("basic_dout0", 32'(data_out), 32'h0);
        req = 16'h0;
        tick();
        check("basic_rel_gv", 32'(grant_valid), 32'h0);
        check("basic_rel_grant", 32'(grant), 32'h0);
        check("basic_rel_dv", 32'(data_valid), 32'h1);
        tick();
        check("basic_idle_dv", 32'(data_valid), 32'h0);
        check("basic_idle_dout", 32'(data_out), 32'h0);

        // Round robin between 0 and 15, 8-cycle holds
        reset_a();
        req = 16'h8001; data_in = 16'h0;
        tick();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) begin
                check("rr_sel", 32'(sel), (r % 2) ? 32'd15 : 32'd0);
                check("rr_grant", 32'(grant), (r % 2) ? 32'h8000 : 32'h0001);
                check("rr_gv", 32'(grant_valid), 32'h1);
                tick();
            end
            check("rr_idle_gv", 32'(grant_valid), 32'h0);
            check("rr_idle_grant", 32'(grant), 32'h0);
            tick();
        end

        // Early release; pointer moves past 3 so 5 beats 2
        reset_a();
        req = 16'h0008;
        tick();
        check("early_sel3", 32'(sel), 32'h3);
        tick();
        req = 16'h0024;
        tick();
        check("early_rel_gv", 32'(grant_valid), 32'h0);
        tick();
        check("early_sel5", 32'(sel), 32'h5);
        check("early_grant5", 32'(grant), 32'h0020);

        // Wrap-around from ptr 15
        reset_a();
        req = 16'h4000;
        tick();
        check("wrap_sel14", 32'(sel), 32'he);
        req = 16'h0006;
        tick();
        check("wrap_rel_gv", 32'(grant_valid), 32'h0);
        tick();
        check("wrap_sel1", 32'(sel), 32'h1);
        req = 16'h0004;
        tick();
        check("wrap_rel2_gv", 32'(grant_valid), 32'h0);
        tick();
        check("wrap_sel2", 32'(sel), 32'h2);

        // Reset mid-grant, then other requests ignored while busy
        reset_a();
        req = 16'h0200; data_in = 16'h0200;
        tick();
        check("mid_sel9", 32'(sel), 32'h9);
        req = 16'h0203;
        tick();
        check("mid_hold_sel9", 32'(sel), 32'h9);
        rst_n = 1'b0;
        tick();
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_sel", 32'(sel), 32'h0);
        check("mid_rst_gv", 32'(grant_valid), 32'h0);
        check("mid_rst_dout", 32'(data_out), 32'h0);
        check("mid_rst_dv", 32'(data_valid), 32'h0);
        rst_n = 1'b1; req = 16'h0201;
        tick();
        check("mid_after_sel0", 32'(sel), 32'h0);
        req = 16'h0200;
        tick();
        check("drop_rel_gv", 32'(grant_valid), 32'h0);
        req = 16'h0201;
        tick();
        check("drop_next_sel9", 32'(sel), 32'h9);

        // MAX_HOLD = 1 with everyone requesting
        rst_nb = 1'b1;
        tick();
        for (int i = 0; i < 18; i++) begin
            check("h1_sel", 32'(sel_b), 32'(i % 16));
            check("h1_grant", 32'(grant_b), 32'(16'b1 << (i % 16)));
            check("h1_gv", 32'(gv_b), 32'h1);
            tick();
            check("h1_idle_gv", 32'(gv_b), 32'h0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
